bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 4-bit combinational gate block. It takes two WIDTH-bit operands plus an opcode over a valid/ready handshake and applies one of eight bitwise operations. It returns the registered result two cycles later over a second valid/ready handshake, with a delivered-result counter. The block sits between a stimulus/operand source and any downstream consumer that can apply backpressure.

---
 rtl/blp_pkg.sv | 19 +
 rtl/blp_core.sv | 33 +++
 rtl/bitwise_logic_pipe.sv | 124 ++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blp_pkg.sv
// blp_pkg: shared constants for the bitwise_logic_pipe block.
//   OP_W           opcode width in bits
//   DEFAULT_WIDTH  default operand/result width
//   OP_*           opcode encodings understood by blp_core
package blp_pkg;

    localparam int unsigned OP_W          = 3;
    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd6;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

endpackage

// File: rtl/blp_core.sv
// blp_core: purely combinational bitwise operation unit.
// Ports:
//   op  opcode (see blp_pkg OP_*)
//   a   first operand
//   b   second operand (ignored for PASS_A / NOT_A)
//   y   result, same width as the operands
module blp_core
    import blp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_PASS_A: y = a;
            OP_NOT_A:  y = ~a;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: two-stage valid/ready pipeline applying one of eight bitwise
// operations to two WIDTH-bit operands, with a delivered-result counter.
// Optional feature macro: BLP_ACC_EN (adds acc_sel port and a WIDTH-bit accumulator
// that may replace operand a and is reloaded with each accumulate beat's result).
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   in_valid, in_ready     operand handshake
//   op, a, b               opcode and operands
//   acc_sel                (BLP_ACC_EN only) use accumulator in place of a
//   out_valid, out_ready   result handshake
//   y, y_zero              registered result and its zero flag
//   out_count              results accepted downstream, wraps
module bitwise_logic_pipe
    import blp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
`ifdef BLP_ACC_EN
    input  logic             acc_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic [CNT_W-1:0] out_count
);

    logic             v1_q;
    logic [WIDTH-1:0] r1_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             y_zero_q;
    logic [CNT_W-1:0] count_q;

    logic             s2_ready;
    logic             s1_ready;
    logic             accept;
    logic             s2_load;
    logic             drain;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] s1_res;

    // Ready depends only on registered state and out_ready, never on in_valid.
    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        s1_ready = !v1_q || s2_ready;
        accept   = in_valid && s1_ready;
        s2_load  = v1_q && s2_ready;
        drain    = out_valid_q && out_ready;
    end

    assign in_ready  = s1_ready;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_zero    = y_zero_q;
    assign out_count = count_q;

`ifdef BLP_ACC_EN
    logic [WIDTH-1:0] acc_q;

    assign op_a = acc_sel ? acc_q : a;

    // Reloaded on the same edge S1 captures, so back-to-back accumulate beats chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept && acc_sel) begin
            acc_q <= s1_res;
        end
    end
`else
    assign op_a = a;
`endif

    blp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op),
        .a  (op_a),
        .b  (b),
        .y  (s1_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            r1_q        <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_zero_q    <= 1'b1;
            count_q     <= '0;
        end else begin
            // S1: a new beat wins over emptying, covering simultaneous accept and drain.
            if (accept) begin
                r1_q <= s1_res;
                v1_q <= 1'b1;
            end else if (s2_load) begin
                v1_q <= 1'b0;
            end

            // S2: y and y_zero only change on a load, so they hold while stalled.
            if (s2_load) begin
                y_q         <= r1_q;
                y_zero_q    <= (r1_q == '0);
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end

            if (drain) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
module tb_bitwise_logic_pipe;

`ifdef BLP_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       acc_sel = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;

    logic       in_ready, out_valid, y_zero;
    logic [3:0] y;
    logic [7:0] out_count;
    logic       in_ready2, out_valid2, y_zero2;
    logic [3:0] y2;
    logic [1:0] out_count2;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
`ifdef BLP_ACC_EN
        .acc_sel   (acc_sel),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_zero    (y_zero),
        .out_count (out_count)
    );

    // Narrow-counter copy fed identically; exercises counter wrap at 2 bits.
    bitwise_logic_pipe #(.WIDTH(4), .CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .op        (op),
`ifdef BLP_ACC_EN
        .acc_sel   (acc_sel),
`endif
        .a         (a),
        .b         (b),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .y         (y2),
        .y_zero    (y_zero2),
        .out_count (out_count2)
    );

    int         n_vec  = 0;
    int         n_miss = 0;
    int         mcount = 0;
    logic [3:0] acc_m  = 4'd0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the eight operations straight from the opcode table.
    function automatic logic [3:0] ref_op(input logic [2:0] o, input logic [3:0] x,
                                          input logic [3:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] aa,
                         input logic [3:0] bb, input logic sel, input logic ordy,
                         output logic took);
        logic [3:0] opa;
        logic [3:0] r;
        @(negedge clk);
        in_valid  = v;
        op        = o;
        a         = aa;
        b         = bb;
        acc_sel   = sel;
        out_ready = ordy;
        #1;
        took = rst_n && v && in_ready;
        if (took) begin
            opa = (ACC && sel) ? acc_m : aa;
            r   = ref_op(o, opa, bb);
            exp_q.push_back(r);
            if (ACC && sel) acc_m = r;
        end
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        mcount = 0;
        acc_m  = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_y_zero", y_zero, 1);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_count_w2", out_count2, 0);
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks stall stability.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_y;
    logic       prev_z;
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_out_valid", out_valid, 1);
                    check("stall_y", y, prev_y);
                    check("stall_y_zero", y_zero, prev_z);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL spurious_out: got y=%0h expected no result", y);
                    end else begin
                        e = exp_q.pop_front();
                        check("y", y, e);
                        check("y_zero", y_zero, (e == 4'd0));
                        check("out_count", out_count, mcount % 256);
                        check("out_count_w2", out_count2, mcount % 4);
                        check("y_w2", y2, e);
                        mcount++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_y     = y;
                prev_z     = y_zero;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic t;
        int   waited;
        do_reset();

        // All eight ops on a=1010, b=0101, back to back.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 4'b1010, 4'b0101, 1'b0, 1'b1, t);
        idle(4);
        check("allops_count", out_count, 8);

        // Latency from an empty pipe.
        drive(1'b1, 3'd6, 4'b1010, 4'b0000, 1'b0, 1'b1, t);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, t);
        check("lat_edge1_valid", out_valid, 0);
        drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, t);
        check("lat_edge2_valid", out_valid, 1);
        check("lat_edge2_y", y, 4'b1010);
        idle(2);

        // Streaming: results on consecutive cycles.
        for (int i = 0; i < 7; i++) begin
            drive(i < 5, 3'(i), 4'b1011, 4'b0111, 1'b0, 1'b1, t);
            if (i >= 2) check("stream_valid", out_valid, 1);
        end
        idle(3);

        // Backpressure: two beats buffer, third is refused.
        drive(1'b1, 3'd2, 4'b1100, 4'b0011, 1'b0, 1'b0, t);
        check("bp_accept1", t, 1);
        drive(1'b1, 3'd0, 4'b1111, 4'b1010, 1'b0, 1'b0, t);
        check("bp_accept2", t, 1);
        drive(1'b1, 3'd4, 4'b0001, 4'b0010, 1'b0, 1'b0, t);
        check("bp_accept3", t, 0);
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd4, 4'b0001, 4'b0010, 1'b0, 1'b0, t);
            check("bp_hold_y", y, 4'b1111);
        end
        waited = 0;
        t = 1'b0;
        while (!t && waited < 10) begin
            drive(1'b1, 3'd4, 4'b0001, 4'b0010, 1'b0, 1'b1, t);
            waited++;
        end
        check("bp_release_accept", t, 1);
        idle(4);

        // Accumulator chain, then reset with a beat in flight.
        do_reset();
        if (ACC) begin
            drive(1'b1, 3'd1, 4'b1111, 4'b0011, 1'b1, 1'b1, t);
            drive(1'b1, 3'd2, 4'b1111, 4'b0101, 1'b1, 1'b1, t);
            idle(3);
        end
        drive(1'b1, 3'd1, 4'b1001, 4'b0110, 1'b1, 1'b1, t);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, t);
            check("flush_no_out", out_valid, 0);
        end
        drive(1'b1, 3'd6, 4'b1101, 4'b0000, 1'b1, 1'b1, t);
        idle(3);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 3'($urandom % 8), 4'($urandom), 4'($urandom),
                  1'($urandom), ($urandom % 4) != 0, t);
        end
        idle(6);
        check("drain_empty", exp_q.size(), 0);
        check("final_count", out_count, mcount % 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
